line_writer: RTL and testbench
==============================

LINE_WRITER -- requirements
Module: line_writer

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 10, the character-memory address width.
REQ-002 The block SHALL have parameter LINE_W, default 8, the line-index width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port clear  input  1  one-cycle pulse, honoured only in IDLE; rewinds the free pointer to 0.
REQ-006 The block SHALL have port line_begin  input  1  one-cycle pulse that opens line line_idx.
REQ-007 The block SHALL have port line_idx  input  LINE_W  index of the line being written; sampled on line_begin.
REQ-008 The block SHALL have port ch_valid  input  1  a character pair is present.
REQ-009 The block SHALL have port ch_ready  output  1  the pair is accepted this cycle when ch_valid is also high.
REQ-010 The block SHALL have port lhs  input  8  ASCII input character.
REQ-011 The block SHALL have port rhs  input  8  ASCII transformed character.
REQ-012 The block SHALL have port line_end  input  1  one-cycle pulse that closes the open line.
REQ-013 The block SHALL have port mem_we, mem_addr, mem_din  output  1/MEM_AW/16  character-memory write; mem_din = {lhs, rhs}.
REQ-014 The block SHALL have port ptr_we, ptr_idx, ptr_din  output  1/LINE_W/20  pointer-table write; ptr_din = {len[9:0], start[9:0]}.
REQ-015 The block SHALL have port busy  output  1  high when the state is not IDLE.
REQ-016 The block SHALL have port overflow  output  1  sticky; cleared by reset or clear.

Function
REQ-017 States SHALL be: IDLE, STREAM and COMMIT.
REQ-018 IDLE + line_begin SHALL go to STREAM; it latches line_idx and sets start = free_ptr and len = 0.
REQ-019 In STREAM, ch_ready SHALL be 1 while free_ptr < 2^MEM_AW, else 0; it is 0 in IDLE and COMMIT.
REQ-020 On accept, the block SHALL drive mem_we = 1, mem_addr = free_ptr and mem_din = {lhs, rhs} in the next cycle (registered, 1-cycle latency), and SHALL increment free_ptr and len.
REQ-021 free_ptr SHALL be MEM_AW+1 bits and SHALL never wrap; once full, no further writes occur.
REQ-022 ch_valid in STREAM with free_ptr full SHALL set overflow and drop the character.
REQ-023 line_end in STREAM SHALL go to COMMIT; a character accepted in the same cycle SHALL be counted in len.
REQ-024 COMMIT SHALL last exactly 1 cycle: ptr_we = 1, ptr_idx = latched index, ptr_din = {len, start}; it then returns to IDLE.
REQ-025 A zero-length line SHALL commit len = 0 with start = the current free_ptr (truncated to MEM_AW).
REQ-026 line_begin outside IDLE SHALL be ignored, and line_end outside STREAM SHALL be ignored.
REQ-027 clear in IDLE SHALL set free_ptr = 0 and overflow = 0 the next cycle; clear outside IDLE SHALL be ignored.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, free_ptr 0, ch_ready 0, mem_we 0, ptr_we 0, mem_addr 0, mem_din 0, ptr_idx 0, ptr_din 0, busy 0, overflow 0.
REQ-029 Reset mid-line SHALL abandon the line with no ptr_we; already-written characters remain in memory but are unreferenced.

Configuration
REQ-030 With LINE_WRITER_STATS_EN defined, the block SHALL add output line_count[LINE_W-1:0], incremented on each ptr_we (wrapping) and zeroed by reset or clear.
REQ-031 Without LINE_WRITER_STATS_EN, the line_count port and its counter SHALL be absent.

Structure
REQ-032 A shared package txform_pkg SHALL hold MEM_AW, LINE_W, the 20-bit pointer-entry layout (START_LSB = 0, LEN_LSB = 10) and the state enum; the transformer read side uses the same layout.
REQ-033 The block SHALL be a single module with no sub-modules.

Verification
REQ-034 After reset, line_begin(idx = 3) then 4 pairs then line_end SHALL produce mem writes at addresses 0..3 and ptr_we with ptr_idx = 3, ptr_din = {10'd4, 10'd0}.
REQ-035 A second line (idx = 7) of 2 pairs SHALL produce writes at 4..5 and ptr_din = {10'd2, 10'd4}.
REQ-036 line_begin then line_end with no chars SHALL produce ptr_din = {10'd0, free_ptr}.
REQ-037 Writing 1025 pairs SHALL give 1024 writes; ch_ready = 0 after the 1024th; overflow = 1; commit has len = 0 (10-bit truncation of 1024), the documented wrap case.
REQ-038 A final char accepted in the same cycle as line_end SHALL be counted; rst_n pulsed mid-STREAM SHALL produce no ptr_we and busy = 0 immediately.

Source files
------------

// File: rtl/txform_pkg.sv
// Shared definitions for the text-transform line writer and its read side:
// default sizes, the 20-bit pointer-table entry layout and the writer state encoding.
package txform_pkg;

    localparam int MEM_AW    = 10;
    localparam int LINE_W    = 8;
    localparam int CHAR_W    = 8;
    localparam int PAIR_W    = 2 * CHAR_W;
    localparam int FIELD_W   = 10;
    localparam int START_LSB = 0;
    localparam int LEN_LSB   = 10;
    localparam int PTR_W     = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic [PTR_W-1:0] pack_ptr(
        input logic [FIELD_W-1:0] len,
        input logic [FIELD_W-1:0] start
    );
        logic [PTR_W-1:0] entry;
        entry = '0;
        entry[LEN_LSB +: FIELD_W]   = len;
        entry[START_LSB +: FIELD_W] = start;
        return entry;
    endfunction

    function automatic logic [FIELD_W-1:0] ptr_len(input logic [PTR_W-1:0] entry);
        return entry[LEN_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] ptr_start(input logic [PTR_W-1:0] entry);
        return entry[START_LSB +: FIELD_W];
    endfunction

endpackage

// File: rtl/line_writer.sv
// Streams character pairs of one line into character memory, then commits {len, start} to the pointer table.
// Optional build macro LINE_WRITER_STATS_EN adds a wrapping line_count output.
module line_writer #(
    parameter int MEM_AW = txform_pkg::MEM_AW,
    parameter int LINE_W = txform_pkg::LINE_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          line_begin,
    input  logic [LINE_W-1:0]             line_idx,
    input  logic                          ch_valid,
    output logic                          ch_ready,
    input  logic [txform_pkg::CHAR_W-1:0] lhs,
    input  logic [txform_pkg::CHAR_W-1:0] rhs,
    input  logic                          line_end,
    output logic                          mem_we,
    output logic [MEM_AW-1:0]             mem_addr,
    output logic [txform_pkg::PAIR_W-1:0] mem_din,
    output logic                          ptr_we,
    output logic [LINE_W-1:0]             ptr_idx,
    output logic [txform_pkg::PTR_W-1:0]  ptr_din,
    output logic                          busy,
    output logic                          overflow
`ifdef LINE_WRITER_STATS_EN
    ,
    output logic [LINE_W-1:0]             line_count
`endif
);
    import txform_pkg::*;

    localparam int PW = MEM_AW + 1;

    state_t              r_state;
    logic [PW-1:0]       r_free_ptr;
    logic [MEM_AW-1:0]   r_start;
    logic [PW-1:0]       r_len;
    logic [LINE_W-1:0]   r_idx;
    logic                r_mem_we;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic [PAIR_W-1:0]   r_mem_din;
    logic                r_ptr_we;
    logic [LINE_W-1:0]   r_ptr_idx;
    logic [PTR_W-1:0]    r_ptr_din;
    logic                r_overflow;
`ifdef LINE_WRITER_STATS_EN
    logic [LINE_W-1:0]   r_line_count;
`endif

    logic                w_full;
    logic                w_ready;
    logic                w_accept;
    logic [PW-1:0]       w_len_next;
    logic [FIELD_W-1:0]  w_len_field;
    logic [FIELD_W-1:0]  w_start_field;

    // The pointer carries one extra bit so "full" is its MSB and it never wraps back onto live data.
    assign w_full        = r_free_ptr[MEM_AW];
    assign w_ready       = (r_state == STREAM) && !w_full;
    assign w_accept      = ch_valid && w_ready;
    assign w_len_next    = r_len + PW'(w_accept);
    assign w_len_field   = FIELD_W'(w_len_next);
    assign w_start_field = FIELD_W'(r_start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_free_ptr   <= '0;
            r_start      <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_ptr_we     <= 1'b0;
            r_ptr_idx    <= '0;
            r_ptr_din    <= '0;
            r_overflow   <= 1'b0;
`ifdef LINE_WRITER_STATS_EN
            r_line_count <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            r_ptr_we <= 1'b0;

            if (w_accept) begin
                r_mem_we   <= 1'b1;
                r_mem_addr <= r_free_ptr[MEM_AW-1:0];
                r_mem_din  <= {lhs, rhs};
                r_free_ptr <= r_free_ptr + PW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (clear) begin
                        r_free_ptr   <= '0;
                        r_overflow   <= 1'b0;
`ifdef LINE_WRITER_STATS_EN
                        r_line_count <= '0;
`endif
                    end
                    if (line_begin) begin
                        r_state <= STREAM;
                        r_idx   <= line_idx;
                        r_start <= clear ? '0 : r_free_ptr[MEM_AW-1:0];
                        r_len   <= '0;
                    end
                end

                STREAM: begin
                    if (ch_valid && w_full) begin
                        r_overflow <= 1'b1;
                    end
                    r_len <= w_len_next;
                    // A pair accepted alongside line_end is already folded into w_len_next.
                    if (line_end) begin
                        r_state   <= COMMIT;
                        r_ptr_we  <= 1'b1;
                        r_ptr_idx <= r_idx;
                        r_ptr_din <= pack_ptr(w_len_field, w_start_field);
                    end
                end

                COMMIT: begin
                    r_state      <= IDLE;
`ifdef LINE_WRITER_STATS_EN
                    r_line_count <= r_line_count + LINE_W'(1);
`endif
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ch_ready   = w_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    assign ptr_we     = r_ptr_we;
    assign ptr_idx    = r_ptr_idx;
    assign ptr_din    = r_ptr_din;
    assign busy       = (r_state != IDLE);
    assign overflow   = r_overflow;
`ifdef LINE_WRITER_STATS_EN
    assign line_count = r_line_count;
`endif

endmodule

// File: tb/tb_line_writer.sv
// Self-checking bench for line_writer: a queue-based model of expected memory and
// pointer-table writes is compared against the DUT on every negative clock edge.
module tb_line_writer;

    localparam int MEM_AW    = 10;
    localparam int LINE_W    = 8;
    localparam int MEM_DEPTH = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              line_begin = 1'b0;
    logic [LINE_W-1:0] line_idx = '0;
    logic              ch_valid = 1'b0;
    logic              ch_ready;
    logic [7:0]        lhs = '0;
    logic [7:0]        rhs = '0;
    logic              line_end = 1'b0;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              ptr_we;
    logic [LINE_W-1:0] ptr_idx;
    logic [19:0]       ptr_din;
    logic              busy;
    logic              overflow;
`ifdef LINE_WRITER_STATS_EN
    logic [LINE_W-1:0] line_count;
`endif

    line_writer #(.MEM_AW(MEM_AW), .LINE_W(LINE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .line_begin (line_begin),
        .line_idx   (line_idx),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .lhs        (lhs),
        .rhs        (rhs),
        .line_end   (line_end),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .ptr_we     (ptr_we),
        .ptr_idx    (ptr_idx),
        .ptr_din    (ptr_din),
        .busy       (busy),
        .overflow   (overflow)
`ifdef LINE_WRITER_STATS_EN
        ,
        .line_count (line_count)
`endif
    );

    always #5 clk = ~clk;

    int nAssert = 0;
    int nFail   = 0;

    // Model: what a writer obeying the line protocol must have done so far.
    int          m_free   = 0;
    int          m_start  = 0;
    int          m_len    = 0;
    int          m_lines  = 0;
    logic [7:0]  m_idx    = '0;
    bit          m_busy   = 0;
    bit          m_stream = 0;
    bit          m_commit = 0;
    bit          m_ov     = 0;
    logic [25:0] memQ[$];
    logic [27:0] ptrQ[$];

    bit          checkEn     = 0;
    int          memWrites   = 0;
    int          ptrWrites   = 0;
    logic [7:0]  lastPtrIdx  = '0;
    logic [19:0] lastPtrDin  = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances after the edge that samples it.
    task automatic applyStimulus(input logic beg, input logic [7:0] idx, input logic v,
                                 input logic [7:0] l, input logic [7:0] r,
                                 input logic en, input logic clr);
        logic [9:0] a10;
        logic [9:0] len10;
        logic [9:0] st10;
        line_begin = beg;
        line_idx   = idx;
        ch_valid   = v;
        lhs        = l;
        rhs        = r;
        line_end   = en;
        clear      = clr;
        @(posedge clk);
        if (m_commit) begin
            m_commit = 0;
            m_busy   = 0;
        end else if (!m_busy) begin
            if (clr) begin
                m_free  = 0;
                m_ov    = 0;
                m_lines = 0;
            end
            if (beg) begin
                m_busy   = 1;
                m_stream = 1;
                m_idx    = idx;
                m_start  = m_free;
                m_len    = 0;
            end
        end else if (m_stream) begin
            if (v) begin
                if (m_free < MEM_DEPTH) begin
                    a10 = m_free[9:0];
                    memQ.push_back({a10, l, r});
                    m_free++;
                    m_len++;
                end else begin
                    m_ov = 1;
                end
            end
            if (en) begin
                len10 = m_len[9:0];
                st10  = m_start[9:0];
                ptrQ.push_back({m_idx, len10, st10});
                m_stream = 0;
                m_commit = 1;
                m_lines++;
            end
        end
        #1;
        line_begin = 1'b0;
        ch_valid   = 1'b0;
        line_end   = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic sendPair(input logic [7:0] l, input logic [7:0] r);
        applyStimulus(1'b0, 8'd0, 1'b1, l, r, 1'b0, 1'b0);
    endtask

    task automatic beginLine(input logic [7:0] idx);
        applyStimulus(1'b1, idx, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic endLine();
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        idleCycle();
        idleCycle();
    endtask

    task automatic clearPulse();
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [25:0] me;
        logic [27:0] pe;
        if (checkEn) begin
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("ch_ready", 32'(ch_ready), 32'(m_stream && (m_free < MEM_DEPTH)));
            checkOutput("overflow", 32'(overflow), 32'(m_ov));
            checkOutput("mem_we", 32'(mem_we), 32'(memQ.size() != 0));
            if (memQ.size() != 0) begin
                me = memQ.pop_front();
                if (mem_we) begin
                    checkOutput("mem_addr", 32'(mem_addr), 32'(me[25:16]));
                    checkOutput("mem_din", 32'(mem_din), 32'(me[15:0]));
                end
            end
            if (mem_we) memWrites++;
            checkOutput("ptr_we", 32'(ptr_we), 32'(ptrQ.size() != 0));
            if (ptrQ.size() != 0) begin
                pe = ptrQ.pop_front();
                if (ptr_we) begin
                    checkOutput("ptr_idx", 32'(ptr_idx), 32'(pe[27:20]));
                    checkOutput("ptr_din", 32'(ptr_din), 32'(pe[19:0]));
                end
            end
            if (ptr_we) begin
                ptrWrites++;
                lastPtrIdx = ptr_idx;
                lastPtrDin = ptr_din;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int ptrBase;

        // Reset values.
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ch_ready", 32'(ch_ready), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_din", 32'(mem_din), 32'd0);
        checkOutput("rst_ptr_we", 32'(ptr_we), 32'd0);
        checkOutput("rst_ptr_idx", 32'(ptr_idx), 32'd0);
        checkOutput("rst_ptr_din", 32'(ptr_din), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkEn = 1;

        // Line 3: four pairs at addresses 0..3.
        beginLine(8'd3);
        sendPair("a", "A");
        sendPair("b", "B");
        sendPair("c", "C");
        sendPair("d", "D");
        endLine();
        checkOutput("l3_ptr_idx", 32'(lastPtrIdx), 32'd3);
        checkOutput("l3_ptr_din", 32'(lastPtrDin), 32'h01000);
        checkOutput("l3_writes", 32'(memWrites), 32'd4);

        // Line 7: second pair arrives together with line_end.
        beginLine(8'd7);
        sendPair("x", "X");
        applyStimulus(1'b0, 8'd0, 1'b1, "y", "Y", 1'b1, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("l7_ptr_idx", 32'(lastPtrIdx), 32'd7);
        checkOutput("l7_ptr_din", 32'(lastPtrDin), 32'h00804);
        checkOutput("l7_writes", 32'(memWrites), 32'd6);

        // Zero-length line 9.
        beginLine(8'd9);
        endLine();
        checkOutput("l9_ptr_din", 32'(lastPtrDin), 32'h00006);
`ifdef LINE_WRITER_STATS_EN
        checkOutput("line_count", 32'(line_count), 32'd3);
`endif

        // Stray controls: line_end in IDLE, line_begin and clear inside STREAM.
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        beginLine(8'd10);
        applyStimulus(1'b1, 8'd20, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        sendPair("q", "Q");
        endLine();
        checkOutput("l10_ptr_idx", 32'(lastPtrIdx), 32'd10);
        checkOutput("l10_ptr_din", 32'(lastPtrDin), 32'h00406);

        // Fill memory from zero and overrun by one pair.
        clearPulse();
        base = memWrites;
        beginLine(8'd5);
        for (int i = 0; i < MEM_DEPTH + 1; i++) begin
            sendPair(8'(i), 8'(~i));
        end
        endLine();
        checkOutput("full_writes", 32'(memWrites - base), 32'd1024);
        checkOutput("full_overflow", 32'(overflow), 32'd1);
        checkOutput("full_ptr_idx", 32'(lastPtrIdx), 32'd5);
        checkOutput("full_ptr_din", 32'(lastPtrDin), 32'h00000);

        clearPulse();
        idleCycle();
        checkOutput("clear_overflow", 32'(overflow), 32'd0);
`ifdef LINE_WRITER_STATS_EN
        checkOutput("clear_line_count", 32'(line_count), 32'd0);
`endif

        // Reset mid-line: no commit, busy drops at once.
        ptrBase = ptrWrites;
        beginLine(8'd2);
        sendPair("m", "M");
        sendPair("n", "N");
        #6;
        rst_n = 1'b0;
        m_free = 0; m_busy = 0; m_stream = 0; m_commit = 0; m_ov = 0; m_lines = 0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_ptr_we", 32'(ptr_we), 32'd0);
        checkOutput("midrst_ch_ready", 32'(ch_ready), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_no_commit", 32'(ptrWrites - ptrBase), 32'd0);

        beginLine(8'd1);
        sendPair("z", "Z");
        endLine();
        checkOutput("post_rst_ptr_din", 32'(lastPtrDin), 32'h00400);

        checkOutput("memQ_drained", 32'(memQ.size()), 32'd0);
        checkOutput("ptrQ_drained", 32'(ptrQ.size()), 32'd0);
        checkEn = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
